id_stage: RTL

//  Instruction-decode pipeline stage directly downstream of instruction fetch. Latches the
//  9-bit instruction read from instruction ROM at the fetch PC, decodes its fields, and

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/branch_lut.sv | 22 ++
 rtl/id_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
//   Shared definitions for the instruction-decode stage.
//   - opcode_t    : 3-bit opcode encoding (ADD..SPC)
//   - id_state_t  : program-completion FSM states (RUN, DRAIN, DONE)
//   - OP_BR       : opcode value of the branch instruction
//   - BR_LUT      : fixed branch-target table, indexed by Instr[4:0]
//   - PC_W_DEFAULT / INSTR_W_DEFAULT : default datapath widths
// ----------------------------------------------------------------------------
package proc_pkg;

    localparam int PC_W_DEFAULT    = 10;
    localparam int INSTR_W_DEFAULT = 9;
    localparam int LUT_DEPTH       = 32;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        LDR = 3'd3,
        STR = 3'd4,
        MOV = 3'd5,
        BR  = 3'd6,
        SPC = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } id_state_t;

    localparam logic [2:0] OP_BR = 3'(BR);

    // Lower half: short forward targets; upper half: far targets in the
    // second half of program memory.
    localparam logic [PC_W_DEFAULT-1:0] BR_LUT [0:LUT_DEPTH-1] = '{
        10'h008, 10'h010, 10'h018, 10'h020, 10'h028, 10'h030, 10'h038, 10'h040,
        10'h048, 10'h050, 10'h058, 10'h060, 10'h068, 10'h070, 10'h078, 10'h080,
        10'h230, 10'h233, 10'h236, 10'h239, 10'h23C, 10'h23F, 10'h242, 10'h245,
        10'h248, 10'h24B, 10'h24E, 10'h251, 10'h254, 10'h257, 10'h25A, 10'h25D
    };

endpackage

// File: rtl/branch_lut.sv
// ----------------------------------------------------------------------------
// branch_lut
//   Read-only branch-target lookup, purely combinational.
//   Ports:
//     idx     in   LUT_AW   table index (low bits of the branch instruction)
//     target  out  PC_W     branch target PC
// ----------------------------------------------------------------------------
module branch_lut
    import proc_pkg::*;
#(
    parameter int LUT_AW = 5,
    parameter int PC_W   = PC_W_DEFAULT
) (
    input  logic [LUT_AW-1:0] idx,
    output logic [PC_W-1:0]   target
);

    always_comb begin
        target = PC_W'(BR_LUT[idx]);
    end

endmodule

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage behind fetch. Registers the fetched instruction,
//   splits its fields, resolves branch targets through branch_lut, squashes
//   wrong-path instructions on taken branches and tracks program completion
//   (RUN -> DRAIN -> DONE) with a 2-bit completed-program counter.
//   Ports:
//     CLK        in   1        clock
//     Init       in   1        synchronous active-high reset
//     Start      in   1        leave DONE and start the next program
//     PC_in      in   PC_W     fetch PC of Instr
//     Instr      in   INSTR_W  instruction at PC_in
//     Halt_in    in   1        fetch halt flag
//     Stall      in   1        hold the ID register
//     Taken      in   1        branch resolved taken this cycle
//     Valid      out  1        ID register holds a live instruction
//     Opcode     out  3        registered Instr[8:6]
//     Rd         out  3        registered Instr[5:3]
//     Rs         out  3        registered Instr[2:0]
//     PC_out     out  PC_W     PC of the registered instruction
//     Branch_en  out  1        registered instruction is a live BR
//     Target     out  PC_W     LUT target of the registered instruction, else 0
//     ProgState  out  2        completed-program count (wraps)
//     Done       out  1        high while in DONE
// ----------------------------------------------------------------------------
module id_stage
    import proc_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int INSTR_W      = INSTR_W_DEFAULT,
    parameter int LUT_AW       = 5,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               Init,
    input  logic               Start,
    input  logic [PC_W-1:0]    PC_in,
    input  logic [INSTR_W-1:0] Instr,
    input  logic               Halt_in,
    input  logic               Stall,
    input  logic               Taken,
    output logic               Valid,
    output logic [2:0]         Opcode,
    output logic [2:0]         Rd,
    output logic [2:0]         Rs,
    output logic [PC_W-1:0]    PC_out,
    output logic               Branch_en,
    output logic [PC_W-1:0]    Target,
    output logic [1:0]         ProgState,
    output logic               Done
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // ID register (stage p1) and control state
    logic            valid_p1;
    logic [2:0]      opcode_p1;
    logic [2:0]      rd_p1;
    logic [2:0]      rs_p1;
    logic [PC_W-1:0] pc_p1;
    logic            branch_p1;
    logic [PC_W-1:0] target_p1;
    logic [1:0]      prog_q;
    logic            done_q;
    id_state_t       state_q;
    logic [CNT_W-1:0] drain_cnt_q;

    logic [PC_W-1:0] lut_target;
    logic            in_run;
    logic            squash;
    logic            load;
    logic            halt_take;
    logic [2:0]      instr_op;

    branch_lut #(
        .LUT_AW (LUT_AW),
        .PC_W   (PC_W)
    ) u_branch_lut (
        .idx    (Instr[LUT_AW-1:0]),
        .target (lut_target)
    );

    always_comb begin
        instr_op  = Instr[INSTR_W-1 -: 3];
        in_run    = (state_q == RUN);
        // Outside RUN the register only ever sees bubbles; in RUN a taken
        // branch wins over a stall.
        squash    = Taken || !in_run;
        load      = in_run && !Taken && !Stall;
        // A stalled halt is not captured unless the taken squash moves the
        // pipeline anyway.
        halt_take = in_run && Halt_in && (Taken || !Stall);
    end

    // p0 -> p1: ID register, FSM, drain counter, program counter
    always_ff @(posedge CLK) begin
        if (Init) begin
            valid_p1    <= 1'b0;
            opcode_p1   <= '0;
            rd_p1       <= '0;
            rs_p1       <= '0;
            pc_p1       <= '0;
            branch_p1   <= 1'b0;
            target_p1   <= '0;
            prog_q      <= '0;
            done_q      <= 1'b0;
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            if (squash) begin
                valid_p1  <= 1'b0;
                opcode_p1 <= '0;
                rd_p1     <= '0;
                rs_p1     <= '0;
                pc_p1     <= '0;
                branch_p1 <= 1'b0;
                target_p1 <= '0;
            end else if (load) begin
                valid_p1  <= 1'b1;
                opcode_p1 <= instr_op;
                rd_p1     <= Instr[5:3];
                rs_p1     <= Instr[2:0];
                pc_p1     <= PC_in;
                branch_p1 <= (instr_op == OP_BR);
                target_p1 <= lut_target;
            end

            case (state_q)
                RUN: begin
                    if (halt_take) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        prog_q  <= prog_q + 2'd1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (Start) begin
                        state_q <= RUN;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Valid     = valid_p1;
    assign Opcode    = opcode_p1;
    assign Rd        = rd_p1;
    assign Rs        = rs_p1;
    assign PC_out    = pc_p1;
    assign Branch_en = branch_p1;
    assign Target    = target_p1;
    assign ProgState = prog_q;
    assign Done      = done_q;

endmodule
